// File: rtl/spi_tx_fifo_ctrl.sv
// spi_tx_fifo_ctrl: byte FIFO plus launch controller in front of an 8-bit SPI
// transmitter. Bytes pushed by the parking-system updaters are queued and then
// launched one at a time (SPI_start pulse + send_data). The transmitter's chip
// select tells us when a transfer is in flight. A minimum CS-high gap is kept
// between two transfers.
//
// Optional feature: define SPI_TIMEOUT_EN to enable the transfer watchdog.
// When it is undefined, the FSM waits on CS indefinitely and timeout_err is
// tied to 0.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      asynchronous active-low reset
//   wr_en        push request
//   wr_data      byte to push
//   full         FIFO holds DEPTH entries
//   empty        FIFO holds no entries
//   level        current entry count, 0..DEPTH
//   ovf          sticky overflow flag (a push was rejected)
//   ovf_clr      clears ovf
//   spi_cs_in    transmitter chip select; low means a transfer is in flight
//   SPI_start    one-cycle launch pulse to the transmitter
//   send_data    byte presented to the transmitter, held until the next launch
//   busy         FSM is not idle
//   timeout_err  one-cycle pulse on watchdog expiry (SPI_TIMEOUT_EN only)
module spi_tx_fifo_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  input  logic              ovf_clr,
  input  logic              spi_cs_in,
  output logic              SPI_start,
  output logic [7:0]        send_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOW  = 2'd1,
    S_WAIT_HIGH = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]   level_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_nxt;
  logic               push_ok;
  logic               pop;
  logic               to_hit;
  logic               start_nxt;
  logic               busy_nxt;
  logic [7:0]         send_nxt;

  // A full FIFO rejects a push even when a pop happens in the same cycle.
  assign push_ok = wr_en && !full;
  // Launch only from IDLE, only with data, and never while CS is low.
  assign pop     = (state == S_IDLE) && !empty && spi_cs_in;

  // Entry count update; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, level, flags. Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
      // A rejected push wins over a same-cycle clear.
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
  // Fires in the TIMEOUT_CYCLES-th cycle spent in the current wait state.
  assign to_hit  = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, restarted on every state change.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      to_cnt <= '0;
    end else if (state_nxt != state) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  // Watchdog limit only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pop)             state_nxt = S_WAIT_LOW;
      S_WAIT_LOW:  if (!spi_cs_in)      state_nxt = S_WAIT_HIGH;
      S_WAIT_HIGH: if (spi_cs_in)       state_nxt = S_GAP;
      // GAP lasts GAP_CYCLES cycles, and at least one when GAP_CYCLES is 0.
      S_GAP:       if (gap_cnt <= GAP_W'(1)) state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
    // A stuck transfer is abandoned; its byte is already popped and lost.
    if (to_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    start_nxt = 1'b0;
    send_nxt  = send_data;
    gap_nxt   = gap_cnt;
    busy_nxt  = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pop) begin
          start_nxt = 1'b1;
          send_nxt  = mem[rd_ptr];
        end
      end
      S_WAIT_HIGH: begin
        if (spi_cs_in) begin
          gap_nxt = GAP_W'(GAP_CYCLES);
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        gap_nxt = gap_cnt;
      end
    endcase
  end

  // Output and gap-counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      SPI_start   <= 1'b0;
      send_data   <= 8'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      SPI_start   <= start_nxt;
      send_data   <= send_nxt;
      busy        <= busy_nxt;
      timeout_err <= to_hit;
      gap_cnt     <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_spi_tx_fifo_ctrl.sv
// Directed testbench for spi_tx_fifo_ctrl with a simple transmitter model:
// CS drops one cycle after a SPI_start and stays low hold_len cycles
// (hold_len=0 means CS never drops). Inputs change at negedge+1.
module tb_spi_tx_fifo_ctrl;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'd0;
  logic       ovf_clr   = 1'b0;
  logic       full, empty, ovf, SPI_start, busy, timeout_err;
  logic [3:0] level;
  logic [7:0] send_data;
  logic       spi_cs_in;
  logic       cs_model  = 1'b1;
  logic       stall     = 1'b0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Transmitter model state and launch log.
  int         hold_len = 33;
  int         tx_cnt   = 0;
  logic       tx_pend  = 1'b0;
  int         starts   = 0;
  int         timeouts = 0;
  int         to_cyc   = 0;
  logic [7:0] sent_q[$];
  int         start_cyc_q[$];
  int         start_lvl_q[$];

  assign spi_cs_in = cs_model && !stall;

  spi_tx_fifo_ctrl #(
    .DEPTH(8), .ADDR_W(3), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
    .spi_cs_in(spi_cs_in), .SPI_start(SPI_start), .send_data(send_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // Transmitter model and launch recorder.
  always @(negedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cs_model = 1'b1;
      tx_pend  = 1'b0;
      tx_cnt   = 0;
    end else begin
      if (timeout_err) begin
        timeouts++;
        to_cyc = cyc;
      end
      if (SPI_start) begin
        starts++;
        sent_q.push_back(send_data);
        start_cyc_q.push_back(cyc);
        start_lvl_q.push_back(int'(level));
        tx_pend = (hold_len > 0);
      end else if (tx_pend) begin
        tx_pend  = 1'b0;
        cs_model = 1'b0;
        tx_cnt   = hold_len;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) cs_model = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_log();
    sent_q.delete();
    start_cyc_q.delete();
    start_lvl_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy; n++) tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    tick();
    tick();
    total++; if (full !== 1'b0)        $display("FAIL reset_full: got %b want 0", full); else passed++;
    total++; if (empty !== 1'b1)       $display("FAIL reset_empty: got %b want 1", empty); else passed++;
    total++; if (level !== 4'd0)       $display("FAIL reset_level: got %0d want 0", level); else passed++;
    total++; if (ovf !== 1'b0)         $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    total++; if (SPI_start !== 1'b0)   $display("FAIL reset_start: got %b want 0", SPI_start); else passed++;
    total++; if (send_data !== 8'd0)   $display("FAIL reset_send_data: got %h want 00", send_data); else passed++;
    total++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passed++;
    sys_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int w;
    int s0;
    int b;
    clear_log();
    s0 = starts;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    w = cyc;
    total++; if (level !== 4'd1)     $display("FAIL single_level_after_write: got %0d want 1", level); else passed++;
    total++; if (SPI_start !== 1'b0) $display("FAIL single_start_early: got %b want 0", SPI_start); else passed++;
    tick();
    total++; if (SPI_start !== 1'b1)   $display("FAIL single_start_latency: got %b want 1", SPI_start); else passed++;
    total++; if (send_data !== 8'hA5)  $display("FAIL single_send_data: got %h want a5", send_data); else passed++;
    total++; if (level !== 4'd0)       $display("FAIL single_level_after_pop: got %0d want 0", level); else passed++;
    total++; if (busy !== 1'b1)        $display("FAIL single_busy: got %b want 1", busy); else passed++;
    tick();
    total++; if (SPI_start !== 1'b0)   $display("FAIL single_start_width: got %b want 0", SPI_start); else passed++;
    wait_idle(200);
    b = cyc;
    // launch k=w+1; CS low k+2..k+34; GAP entered at k+35, busy low at k+35+GAP
    total++; if (b !== w + 1 + 2 + 33 + int'(GAP)) $display("FAIL single_busy_fall_cycle: got %0d want %0d", b - w, 1 + 2 + 33 + int'(GAP)); else passed++;
    for (int i = 0; i < 10; i++) tick();
    total++; if (starts - s0 !== 1)    $display("FAIL single_start_count: got %0d want 1", starts - s0); else passed++;
    total++; if (send_data !== 8'hA5)  $display("FAIL single_send_data_hold: got %h want a5", send_data); else passed++;
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [3];
    int         exp_l [3];
    int         w;
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    // launch 1 coincides with push 2, so level reads 1, then 1, then 0
    exp_l[0] = 1;     exp_l[1] = 1;     exp_l[2] = 0;
    clear_log();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = exp_d[i];
      tick();
      if (i == 0) w = cyc;
    end
    wr_en = 1'b0;
    total++; if (level !== 4'd2) $display("FAIL burst_level_after_writes: got %0d want 2", level); else passed++;
    for (int n = 0; n < 300 && sent_q.size() < 3; n++) tick();
    wait_idle(100);
    total++; if (sent_q.size() !== 3) $display("FAIL burst_launch_count: got %0d want 3", sent_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (sent_q.size() <= i || sent_q[i] !== exp_d[i]) $display("FAIL burst_order_%0d: got %h want %h", i, (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp_d[i]); else passed++;
      total++; if (start_lvl_q.size() <= i || start_lvl_q[i] !== exp_l[i]) $display("FAIL burst_level_%0d: got %0d want %0d", i, (start_lvl_q.size() > i) ? start_lvl_q[i] : -1, exp_l[i]); else passed++;
    end
    total++; if (start_cyc_q.size() < 1 || start_cyc_q[0] !== w + 1) $display("FAIL burst_first_latency: got %0d want %0d", (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1, w + 1); else passed++;
    // spacing: 1 (CS drop delay) + 33 (CS low) + 1 (WAIT_HIGH) + GAP + 1 (IDLE)
    for (int i = 1; i < 3; i++) begin
      total++; if (start_cyc_q.size() <= i || start_cyc_q[i] - start_cyc_q[i-1] !== 36 + int'(GAP)) $display("FAIL burst_spacing_%0d: got %0d want %0d", i, (start_cyc_q.size() > i) ? start_cyc_q[i] - start_cyc_q[i-1] : -1, 36 + int'(GAP)); else passed++;
    end
  endtask

  task automatic test_overflow();
    int s0;
    clear_log();
    stall = 1'b1;
    s0 = starts;
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (level !== 4'd8)   $display("FAIL ovf_level: got %0d want 8", level); else passed++;
    total++; if (full !== 1'b1)    $display("FAIL ovf_full: got %b want 1", full); else passed++;
    total++; if (empty !== 1'b0)   $display("FAIL ovf_empty: got %b want 0", empty); else passed++;
    total++; if (ovf !== 1'b1)     $display("FAIL ovf_set: got %b want 1", ovf); else passed++;
    total++; if (starts !== s0)    $display("FAIL ovf_no_launch_cs_low: got %0d want %0d", starts, s0); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0)     $display("FAIL ovf_clear: got %b want 0", ovf); else passed++;
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    ovf_clr = 1'b0; wr_en = 1'b0;
    total++; if (ovf !== 1'b1)     $display("FAIL ovf_set_beats_clear: got %b want 1", ovf); else passed++;
    total++; if (level !== 4'd8)   $display("FAIL ovf_level_unchanged: got %0d want 8", level); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    // Release CS and push in the same cycle as the pop of a full FIFO.
    stall = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++; if (level !== 4'd7)      $display("FAIL popfull_level: got %0d want 7", level); else passed++;
    total++; if (ovf !== 1'b1)        $display("FAIL popfull_ovf: got %b want 1", ovf); else passed++;
    total++; if (SPI_start !== 1'b1)  $display("FAIL popfull_start: got %b want 1", SPI_start); else passed++;
    total++; if (send_data !== 8'h10) $display("FAIL popfull_send_data: got %h want 10", send_data); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    for (int n = 0; n < 500 && sent_q.size() < 8; n++) tick();
    wait_idle(100);
    for (int i = 0; i < 10; i++) tick();
    total++; if (sent_q.size() !== 8) $display("FAIL drain_count: got %0d want 8", sent_q.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (sent_q.size() <= i || sent_q[i] !== 8'h10 + 8'(i)) $display("FAIL drain_order_%0d: got %h want %h", i, (sent_q.size() > i) ? sent_q[i] : 8'hxx, 8'h10 + 8'(i)); else passed++;
    end
    total++; if (empty !== 1'b1 || level !== 4'd0) $display("FAIL drain_empty: got empty=%b level=%0d want 1/0", empty, level); else passed++;
  endtask

  task automatic test_reset_midflight();
    int s0;
    hold_len = 40;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h20 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++; if (level !== 4'd5 || busy !== 1'b1) $display("FAIL midrst_setup: got level=%0d busy=%b want 5/1", level, busy); else passed++;
    total++; if (spi_cs_in !== 1'b0) $display("FAIL midrst_cs_low: got %b want 0", spi_cs_in); else passed++;
    sys_rst = 1'b0;
    #1;
    total++; if (level !== 4'd0)      $display("FAIL midrst_level: got %0d want 0", level); else passed++;
    total++; if (empty !== 1'b1)      $display("FAIL midrst_empty: got %b want 1", empty); else passed++;
    total++; if (full !== 1'b0)       $display("FAIL midrst_full: got %b want 0", full); else passed++;
    total++; if (busy !== 1'b0)       $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (send_data !== 8'd0)  $display("FAIL midrst_send_data: got %h want 00", send_data); else passed++;
    total++; if (SPI_start !== 1'b0)  $display("FAIL midrst_start: got %b want 0", SPI_start); else passed++;
    tick();
    sys_rst = 1'b1;
    hold_len = 33;
    s0 = starts;
    for (int i = 0; i < 60; i++) tick();
    total++; if (starts !== s0)       $display("FAIL midrst_no_launch: got %0d want %0d", starts, s0); else passed++;
    total++; if (busy !== 1'b0 || level !== 4'd0) $display("FAIL midrst_idle: got busy=%b level=%0d want 0/0", busy, level); else passed++;
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tick();
    total++; if (SPI_start !== 1'b1 || send_data !== 8'h5A) $display("FAIL midrst_relaunch: got start=%b data=%h want 1/5a", SPI_start, send_data); else passed++;
    wait_idle(200);
  endtask

  task automatic test_timeout();
    int k;
    int t0;
    clear_log();
    hold_len = 0;
    t0 = timeouts;
    wr_en = 1'b1; wr_data = 8'hC1;
    tick();
    wr_data = 8'hC2;
    tick();
    wr_en = 1'b0;
    k = (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1;
`ifdef SPI_TIMEOUT_EN
    for (int n = 0; n < 40 && timeouts == t0; n++) tick();
    total++; if (to_cyc !== k + int'(TO)) $display("FAIL timeout_cycle: got %0d want %0d", to_cyc - k, TO); else passed++;
    tick();
    total++; if (timeouts - t0 !== 1) $display("FAIL timeout_pulse_width: got %0d want 1", timeouts - t0); else passed++;
    total++; if (start_cyc_q.size() < 2 || start_cyc_q[1] !== k + int'(TO) + 1) $display("FAIL timeout_next_launch: got %0d want %0d", (start_cyc_q.size() > 1) ? start_cyc_q[1] - k : -1, TO + 1); else passed++;
    total++; if (sent_q.size() < 2 || sent_q[1] !== 8'hC2) $display("FAIL timeout_next_byte: got %h want c2", (sent_q.size() > 1) ? sent_q[1] : 8'hxx); else passed++;
    wait_idle(60);
    total++; if (timeouts - t0 !== 2 || level !== 4'd0) $display("FAIL timeout_second: got to=%0d level=%0d want 2/0", timeouts - t0, level); else passed++;
`else
    for (int i = 0; i < 60; i++) tick();
    total++; if (timeouts !== t0)     $display("FAIL no_timeout_pulse: got %0d want %0d", timeouts, t0); else passed++;
    total++; if (busy !== 1'b1)       $display("FAIL no_timeout_busy: got %b want 1", busy); else passed++;
    total++; if (sent_q.size() !== 1) $display("FAIL no_timeout_launches: got %0d want 1", sent_q.size()); else passed++;
    total++; if (level !== 4'd1)      $display("FAIL no_timeout_level: got %0d want 1", level); else passed++;
`endif
    total++; if (k < 0) $display("FAIL timeout_launch_seen: got none want 1"); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_midflight();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
